// File: rtl/negate_rr_scheduler_if.sv
// Handshake bundle for negate_rr_scheduler: requester side plus result port.
// master = clients/consumer side, slave = the scheduler.
interface negate_rr_scheduler_if #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8,
   parameter int ID_W    = 2
);
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ*WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]       req_ready;
   logic                     out_valid;
   logic [WIDTH-1:0]         out_data;
   logic [ID_W-1:0]          out_id;
   logic                     out_ovf;
   logic                     out_ready;

   modport master (
      output req_valid, req_data, out_ready,
      input  req_ready, out_valid, out_data, out_id, out_ovf
   );

   modport slave (
      input  req_valid, req_data, out_ready,
      output req_ready, out_valid, out_data, out_id, out_ovf
   );
endinterface

// File: rtl/negate_rr_scheduler.sv
// negate_rr_scheduler: round-robin sharing of one two's-complement negate
// unit among NUM_REQ requesters, with a one-entry registered result buffer
// tagged by source id and an overflow flag.
// Build option: define NEG_SAT_EN to saturate the most-negative operand to the
// most-positive value instead of wrapping.
module negate_rr_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8,
   parameter int ID_W    = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   negate_rr_scheduler_if.slave  bus
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] MAX_POS = ~MIN_NEG;

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

   state_e                       state_q, state_d;
   logic [IW-1:0]                ptr_q, ptr_d;
   logic [WIDTH-1:0]             data_q, data_d;
   logic [ID_W-1:0]              id_q, id_d;
   logic                         ovf_q, ovf_d;

   logic [NUM_REQ-1:0][WIDTH-1:0] opnd;
   logic                          gnt_vld;
   logic [IW-1:0]                 gnt_sel;
   logic                          can_accept;
   logic                          xfer;
   logic [WIDTH-1:0]              opnd_g;
   logic [WIDTH-1:0]              neg_res;
   logic                          neg_ovf;
   int                            idx;
   int                            nxt;

   // unpack the flat operand bus into per-requester lanes
   always_comb begin
      opnd = '0;
      for (int i = 0; i < NUM_REQ; i++) opnd[i] = bus.req_data[i*WIDTH +: WIDTH];
   end

   // rotating-priority search starting at ptr, first valid requester wins
   always_comb begin
      gnt_vld = 1'b0;
      gnt_sel = '0;
      idx     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!gnt_vld && bus.req_valid[IW'(idx)]) begin
            gnt_vld = 1'b1;
            gnt_sel = IW'(idx);
         end
      end
   end

   // shared negate datapath on the granted operand
   always_comb begin
      opnd_g  = opnd[gnt_sel];
      neg_ovf = (opnd_g == MIN_NEG);
`ifdef NEG_SAT_EN
      neg_res = neg_ovf ? MAX_POS : (~opnd_g + WIDTH'(1));
`else
      neg_res = ~opnd_g + WIDTH'(1);
`endif
   end

   // buffer may take a new result when empty or when it drains this edge;
   // rst_n gating keeps req_ready low during reset
   assign can_accept = (state_q == EMPTY) | bus.out_ready;
   assign xfer       = rst_n & gnt_vld & can_accept;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= EMPTY;
      else        state_q <= state_d;
   end

   // next-state: a transfer always fills, a bare drain empties
   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: if (xfer) state_d = FULL;
         FULL:  if (xfer) state_d = FULL;
                else if (bus.out_ready) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   // outputs: one-hot accept strobe and buffered result
   always_comb begin
      bus.req_ready = '0;
      if (xfer) bus.req_ready[gnt_sel] = 1'b1;
      bus.out_valid = (state_q == FULL);
      bus.out_data  = data_q;
      bus.out_id    = id_q;
      bus.out_ovf   = ovf_q;
   end

   // result payload and priority pointer only move on a transfer
   always_comb begin
      data_d = data_q;
      id_d   = id_q;
      ovf_d  = ovf_q;
      ptr_d  = ptr_q;
      nxt    = int'(gnt_sel) + 1;
      if (nxt >= NUM_REQ) nxt = 0;
      if (xfer) begin
         data_d = neg_res;
         id_d   = ID_W'(gnt_sel);
         ovf_d  = neg_ovf;
         ptr_d  = IW'(nxt);
      end
   end

   // payload and pointer registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         id_q   <= '0;
         ovf_q  <= 1'b0;
         ptr_q  <= '0;
      end else begin
         data_q <= data_d;
         id_q   <= id_d;
         ovf_q  <= ovf_d;
         ptr_q  <= ptr_d;
      end
   end
endmodule

// File: tb/tb_negate_rr_scheduler.sv
// Bench for negate_rr_scheduler: directed vectors, a transaction-level
// reference model compared every cycle, plus literal spot checks.
module tb_negate_rr_scheduler;
   localparam int N = 4;
   localparam int W = 8;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;

   negate_rr_scheduler_if #(.NUM_REQ(N), .WIDTH(W), .ID_W(2)) bus ();

   negate_rr_scheduler #(.NUM_REQ(N), .WIDTH(W), .ID_W(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // reference model state: pointer and the single result slot
   int   m_ptr;
   logic m_vld;
   int   m_data;
   int   m_id;
   logic m_ovf;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int pick();
      int v;
      int j;
      v = int'(bus.req_valid);
      for (int k = 0; k < N; k++) begin
         j = (m_ptr + k) % N;
         if (((v >> j) & 1) == 1) return j;
      end
      return -1;
   endfunction

   function automatic int operand(input int g);
      return (int'(bus.req_data) >> (g * W)) & 255;
   endfunction

   function automatic int neg_model(input int x);
`ifdef NEG_SAT_EN
      if (x == 128) return 127;
`endif
      return (256 - x) & 255;
   endfunction

   // model update on each edge (inputs are driven 1 time unit after the edge)
   always @(posedge clk or negedge rst_n) begin
      int g;
      int x;
      if (!rst_n) begin
         m_ptr = 0; m_vld = 0; m_data = 0; m_id = 0; m_ovf = 0;
      end else begin
         g = pick();
         if (g >= 0 && (!m_vld || bus.out_ready)) begin
            x      = operand(g);
            m_data = neg_model(x);
            m_id   = g;
            m_ovf  = (x == 128);
            m_ptr  = (g + 1) % N;
            m_vld  = 1;
         end else if (m_vld && bus.out_ready) begin
            m_vld = 0;
         end
      end
   end

   // every-cycle comparison against the model
   always @(negedge clk) begin
      logic [3:0] er;
      int g;
      er = '0;
      if (rst_n) begin
         g = pick();
         if (g >= 0 && (!m_vld || bus.out_ready)) er = 4'(1 << g);
      end
      chk("model_req_ready", 32'(bus.req_ready), 32'(er));
      chk("model_out_valid", 32'(bus.out_valid), 32'(m_vld));
      chk("model_out_data",  32'(bus.out_data),  32'(m_data));
      chk("model_out_id",    32'(bus.out_id),    32'(m_id));
      chk("model_out_ovf",   32'(bus.out_ovf),   32'(m_ovf));
   end

   // one clock: note accepts before the edge, retire them after it
   task automatic cycle();
      logic [3:0] acc;
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #1;
      bus.req_valid = bus.req_valid & ~acc;
   endtask

   logic [7:0] fair_exp [4];
   logic [7:0] ovf_exp;

   initial begin
      fair_exp[0] = 8'hFF; fair_exp[1] = 8'hFE; fair_exp[2] = 8'hFD; fair_exp[3] = 8'hFC;
`ifdef NEG_SAT_EN
      ovf_exp = 8'h7F;
`else
      ovf_exp = 8'h80;
`endif
      n_cmp = 0; n_bad = 0;
      clk = 0; rst_n = 0;
      bus.req_data  = {8'h04, 8'h03, 8'h02, 8'h01};
      bus.req_valid = 4'b1111;
      bus.out_ready = 1'b1;

      // reset holds everything quiet even with all requests up
      repeat (2) @(negedge clk);
      #1;
      chk("rst_ready", 32'(bus.req_ready), 32'h0);
      chk("rst_valid", 32'(bus.out_valid), 32'h0);
      @(posedge clk); #1;
      rst_n = 1;
      #1;
      chk("first_grant", 32'(bus.req_ready), 32'h1);

      // fairness: two rounds, each in order 0..3
      for (int r = 0; r < 2; r++) begin
         bus.req_valid = 4'b1111;
         for (int k = 0; k < 4; k++) begin
            cycle();
            chk("fair_id",   32'(bus.out_id),   32'(k));
            chk("fair_data", 32'(bus.out_data), 32'(fair_exp[k]));
         end
      end

      // single request on requester 2
      bus.req_data[2*8 +: 8] = 8'h05;
      bus.req_valid = 4'b0100;
      #1;
      chk("single_ready", 32'(bus.req_ready), 32'h4);
      cycle();
      chk("single_valid", 32'(bus.out_valid), 32'h1);
      chk("single_data",  32'(bus.out_data),  32'hFB);
      chk("single_id",    32'(bus.out_id),    32'h2);
      chk("single_ovf",   32'(bus.out_ovf),   32'h0);
      bus.req_data[2*8 +: 8] = 8'h00;
      bus.req_valid = 4'b0100;
      cycle();
      chk("zero_data", 32'(bus.out_data), 32'h0);
      chk("zero_ovf",  32'(bus.out_ovf),  32'h0);

      // backpressure: id 1 result held while 2 and 3 wait
      cycle();
      bus.req_data[1*8 +: 8] = 8'h11;
      bus.req_valid = 4'b0010;
      bus.out_ready = 1'b0;
      cycle();
      bus.req_data[2*8 +: 8] = 8'h10;
      bus.req_data[3*8 +: 8] = 8'h20;
      bus.req_valid = 4'b1100;
      repeat (5) begin
         cycle();
         chk("bp_ready", 32'(bus.req_ready), 32'h0);
         chk("bp_id",    32'(bus.out_id),    32'h1);
         chk("bp_data",  32'(bus.out_data),  32'hEF);
      end
      bus.out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(bus.req_ready), 32'h4);
      cycle();
      chk("bp_refill_valid", 32'(bus.out_valid), 32'h1);
      chk("bp_refill_id",    32'(bus.out_id),    32'h2);
      chk("bp_refill_data",  32'(bus.out_data),  32'hF0);
      cycle();
      chk("bp_next_id",   32'(bus.out_id),   32'h3);
      chk("bp_next_data", 32'(bus.out_data), 32'hE0);
      cycle();
      chk("drain_valid", 32'(bus.out_valid), 32'h0);

      // overflow boundary
      bus.req_data[0 +: 8] = 8'h80;
      bus.req_valid = 4'b0001;
      cycle();
      chk("ovf_flag", 32'(bus.out_ovf),  32'h1);
      chk("ovf_data", 32'(bus.out_data), 32'(ovf_exp));
      bus.req_data[0 +: 8] = 8'h81;
      bus.req_valid = 4'b0001;
      cycle();
      chk("near_ovf_flag", 32'(bus.out_ovf),  32'h0);
      chk("near_ovf_data", 32'(bus.out_data), 32'h7F);

      // asynchronous reset while holding a result
      bus.req_data[1*8 +: 8] = 8'h33;
      bus.req_valid = 4'b0010;
      bus.out_ready = 1'b0;
      cycle();
      chk("pre_rst_valid", 32'(bus.out_valid), 32'h1);
      #3;
      rst_n = 0;
      #2;
      chk("async_rst_valid", 32'(bus.out_valid), 32'h0);
      chk("async_rst_ready", 32'(bus.req_ready), 32'h0);
      @(posedge clk); #1;
      bus.req_data  = {8'h04, 8'h03, 8'h02, 8'h01};
      bus.req_valid = 4'b1111;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      rst_n = 1;
      #1;
      chk("post_rst_valid", 32'(bus.out_valid), 32'h0);
      chk("post_rst_grant", 32'(bus.req_ready), 32'h1);
      cycle();
      chk("post_rst_id",   32'(bus.out_id),   32'h0);
      chk("post_rst_data", 32'(bus.out_data), 32'hFF);
      bus.req_valid = 4'b0000;
      repeat (3) cycle();
      chk("final_valid", 32'(bus.out_valid), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/negate_rr_scheduler.md
Name: negate_rr_scheduler

Overview:
- Shares a single 8-bit two's-complement negation datapath (y = ~x + 1) among NUM_REQ independent requesters.
- Arbitration is round-robin with a valid/ready handshake on every requester and on the single result port.
- The result is registered in a one-entry output buffer, tagged with the source requester ID and an overflow flag.
- Sits between the arithmetic clients and the shared negate unit in the datapath.

Parameters:
- NUM_REQ, 4, number of requesters; legal values 2..8.
- WIDTH, 8, operand and result width in bits.
- ID_W, 2, width of out_id; must be at least clog2(NUM_REQ).

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_data  in  NUM_REQ*WIDTH  packed operands; requester i uses bits [i*WIDTH +: WIDTH].
- req_ready  out  NUM_REQ  per-requester accept strobe; one-hot or zero.
- out_valid  out  1  result register holds a valid result.
- out_data  out  WIDTH  negated operand.
- out_id  out  ID_W  index of the requester that produced the result.
- out_ovf  out  1  operand was the most-negative value (1 followed by WIDTH-1 zeros).
- out_ready  in  1  consumer accepts the result.

Behaviour:
- Reset: asynchronous, active-low, takes effect immediately.
  - out_valid=0, out_data=0, out_id=0, out_ovf=0.
  - Priority pointer ptr=0; state=EMPTY.
  - req_ready is all zero while rst_n=0.
- States:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- can_accept = (state==EMPTY) | out_ready.
- Arbitration (combinational):
  - Search req_valid starting at index ptr, ascending with wrap-around modulo NUM_REQ.
  - The first asserted requester wins (grant g).
  - req_ready[g] = can_accept; every other req_ready bit is 0.
  - If no req_valid is asserted, req_ready is all zero.
- Transfer: occurs on a clock edge with req_valid[g] & req_ready[g]. On that edge:
  - out_data <= ~req_data[g] + 1, truncated to WIDTH bits.
  - out_id <= g.
  - out_ovf <= (operand == 1 followed by WIDTH-1 zeros).
  - ptr <= (g+1) mod NUM_REQ.
  - state <= FULL.
- Drain without refill: edge with out_valid & out_ready and no transfer -> state <= EMPTY, out_valid <= 0. Data, id and ovf registers hold their values.
- Simultaneous drain and transfer: the new result replaces the old one on the same edge, state stays FULL. Sustained throughput is one result per cycle.
- Backpressure: while FULL and out_ready=0, req_ready is all zero. out_data, out_id and out_ovf stay stable. ptr does not move.
- Latency: operand accepted at edge t, result visible after edge t (out_valid=1 in cycle t+1).
- ptr advances only on a transfer. Idle cycles never move it.
- Requesters hold req_valid and req_data stable until accepted. Dropping req_valid before acceptance is allowed; that requester simply loses its request.
- Operand 0 -> result 0, ovf 0.
- Reset asserted mid-transaction: any pending result is discarded and nothing is replayed after reset.

Optional Feature:
- Macro: NEG_SAT_EN.
- Defined: when out_ovf is set, out_data is saturated to the most-positive value (0 followed by WIDTH-1 ones; 0x7F for WIDTH=8). All other operands negate normally.
- Undefined: pure wrap-around. The most-negative operand returns itself (0x80 -> 0x80), and out_ovf is still reported.
- Handshake timing and arbitration are identical in both builds.

Test Plan:
- Reset: hold rst_n=0 with req_valid=4'b1111 -> out_valid=0, req_ready=4'b0000. Release reset with req_valid=4'b1111 and out_ready=1 -> first grant goes to requester 0.
- Single request: req_valid=4'b0100, data2=0x05, out_ready=1 -> req_ready=4'b0100 for one edge. Next cycle: out_valid=1, out_data=0xFB, out_id=2, out_ovf=0. Repeat with data2=0x00 -> out_data=0x00.
- Fairness: all four requesters valid (data 0x01, 0x02, 0x03, 0x04), out_ready=1 -> results on consecutive cycles in order id 0,1,2,3 with out_data 0xFF, 0xFE, 0xFD, 0xFC. Re-raise all four -> order 0,1,2,3 again.
- Backpressure: result id 1 pending with out_ready=0 for 5 cycles and requesters 2 and 3 valid -> req_ready=0 throughout, output stable. Raise out_ready -> requester 2 is accepted on the same edge the result drains, and out_valid stays 1.
- Overflow: operand 0x80 -> out_ovf=1. out_data=0x80 without NEG_SAT_EN, 0x7F with it. Operand 0x81 -> 0x7F, ovf=0 in both builds.
- Reset mid-operation: assert rst_n=0 asynchronously while FULL, between clock edges -> out_valid falls before the next edge. After release, ptr=0 and no stale result reappears.
